// File: rtl/pmod_input_conditioner.sv
// PMOD pin front end: per-channel synchroniser and counting debouncer, with
// registered edge pulses and optional press-toggle latches.
module pmod_input_conditioner #(
   parameter int                NCH             = 4,
   parameter int                SYNC_STAGES     = 2,
   parameter int                DEBOUNCE_CYCLES = 60000,
   parameter int                CNT_W           = 16,
   parameter logic [NCH-1:0]    TOGGLE_MASK     = 4'b0100
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [NCH-1:0] raw_in,
   output logic [NCH-1:0] level_out,
   output logic [NCH-1:0] rise_pulse,
   output logic [NCH-1:0] fall_pulse,
   output logic [NCH-1:0] toggle_out,
   output logic           any_change
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [NCH-1:0]   sync_q   [SYNC_STAGES];
   logic [NCH-1:0]   sync_d   [SYNC_STAGES];
   logic [NCH-1:0]   synced;
   logic [NCH-1:0]   stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q    [NCH];
   logic [CNT_W-1:0] cnt_d    [NCH];
   logic [NCH-1:0]   rise_q, rise_d;
   logic [NCH-1:0]   fall_q, fall_d;
   logic [NCH-1:0]   toggle_q, toggle_d;

   assign synced = sync_q[SYNC_STAGES-1];

   // Only the first stage ever sees the raw pins.
   always_comb begin
      sync_d[0] = raw_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
   end

   // cnt counts consecutive cycles in which synced disagrees with stable;
   // any agreement restarts it, so chatter never accumulates.
   always_comb begin
      stable_d = stable_q;
      rise_d   = '0;
      fall_d   = '0;
      for (int i = 0; i < NCH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (synced[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            stable_d[i] = synced[i];
            cnt_d[i]    = '0;
            rise_d[i]   = synced[i];
            fall_d[i]   = ~synced[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end
      end
   end

   // Toggle reacts to the registered pulse, so it lands one cycle after it.
   always_comb begin
      toggle_d = toggle_q ^ (rise_q & TOGGLE_MASK);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= '0;
         end
         stable_q <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         toggle_q <= '0;
      end else begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_d[s];
         end
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         stable_q <= stable_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         toggle_q <= toggle_d;
      end
   end

   assign level_out  = stable_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign toggle_out = toggle_q;
   assign any_change = |{rise_q, fall_q};

endmodule
